main_mem_responder: RTL and testbench

//  Synthesizable main-memory (DRAM-side) responder for the cache_controller miss/write-through port.
//  - Accepts one block-read or one word-write request at a time.
//  - Applies a fixed latency, then returns a 512-bit block or commits a 32-bit word.
//  - Pulses main_mem_ready for one cycle to complete each request.
//  - Sits between cache_controller and the memory array; replaces behavioural memory models in sim and FPGA.

---
 rtl/mem_pkg.sv | 31 +++
 rtl/main_mem_array.sv | 54 +++++
 rtl/main_mem_responder.sv | 110 +++++++++++
 tb/tb_main_mem_responder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory responder: block geometry, FSM states,
// operation types and the latched request record.
package mem_pkg;

   localparam int OFFSET_BITS     = 6;
   localparam int BLOCK_BITS      = 512;
   localparam int WORD_BITS       = 32;
   localparam int WORDS_PER_BLOCK = 16;
   localparam int WORD_SEL_BITS   = $clog2(WORDS_PER_BLOCK);
   localparam int BLK_IDX_BITS    = 32 - OFFSET_BITS;
   localparam int LANE_LSB_BITS   = $clog2(BLOCK_BITS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_e;

   typedef struct packed {
      op_e                      op;
      logic [BLK_IDX_BITS-1:0]  blk;
      logic [WORD_SEL_BITS-1:0] word;
      logic [WORD_BITS-1:0]     wdata;
   } req_t;

endpackage

// File: rtl/main_mem_array.sv
// Block storage for the responder: one 512-bit entry per block, 32-bit word-select
// writes and a registered full-block read port with a synchronous clear.
module main_mem_array
   import mem_pkg::*;
#(
   parameter int DEPTH_BLOCKS = 1024,
   parameter int INIT_PATTERN = 1,
   parameter int IDX_W        = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rd_en,
   input  logic                     rd_clr,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         idx,
   input  logic [WORD_SEL_BITS-1:0] word,
   input  logic [WORD_BITS-1:0]     wdata,
   output logic [BLOCK_BITS-1:0]    rdata
);

   logic [BLOCK_BITS-1:0]    blk_w [DEPTH_BLOCKS];
   logic [BLOCK_BITS-1:0]    rdata_q;
   logic [LANE_LSB_BITS-1:0] lane_lsb;

   assign lane_lsb = {word, 5'b0};

   for (genvar b = 0; b < DEPTH_BLOCKS; b++) begin : g_blk
      // NOTE: storage carries a power-up value but no reset, so a controller reset
      // never disturbs memory contents and the array maps onto plain RAM/flops.
      logic [BLOCK_BITS-1:0] blk_q = (INIT_PATTERN != 0) ? BLOCK_BITS'(b) : '0;

      always_ff @(posedge clk) begin
         if (wr_en && (idx == IDX_W'(b))) begin
            blk_q[lane_lsb +: WORD_BITS] <= wdata;
         end
      end

      assign blk_w[b] = blk_q;
   end

   // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (rd_clr) begin
         rdata_q <= '0;
      end else if (rd_en) begin
         rdata_q <= blk_w[idx];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/main_mem_responder.sv
// DRAM-side responder for the cache controller: accepts one block read or word write,
// waits a fixed latency, performs it against main_mem_array and pulses ready once.
module main_mem_responder
   import mem_pkg::*;
#(
   parameter int LATENCY_CYCLES = 3,
   parameter int DEPTH_BLOCKS   = 1024,
   parameter int INIT_PATTERN   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           main_mem_addr,
   input  logic [WORD_BITS-1:0]  main_mem_data_out,
   input  logic                  main_mem_read_req,
   input  logic                  main_mem_write_req,
   output logic [BLOCK_BITS-1:0] main_mem_data_in,
   output logic                  main_mem_ready,
   output logic                  main_mem_busy,
   output logic                  main_mem_addr_err
);

   localparam int IDX_W = (DEPTH_BLOCKS > 1) ? $clog2(DEPTH_BLOCKS) : 1;
   localparam int CNT_W = (LATENCY_CYCLES > 0) ? $clog2(LATENCY_CYCLES + 1) : 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   req_t             req_q, req_d;
   logic             err_q, err_d;

   logic in_range;
   logic perform;
   logic arr_rd_en, arr_rd_clr, arr_wr_en;
   logic unused_addr_bits;

   assign unused_addr_bits = ^main_mem_addr[1:0];
   assign in_range = ({{(32 - BLK_IDX_BITS){1'b0}}, req_q.blk} < 32'(DEPTH_BLOCKS));
   assign perform  = (state_q == ST_WAIT) && (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      err_d   = err_q;
      unique case (state_q)
         ST_IDLE: begin
            // Write wins a simultaneous request; the losing read is simply dropped.
            if (main_mem_write_req || main_mem_read_req) begin
               state_d     = ST_WAIT;
               cnt_d       = CNT_W'(LATENCY_CYCLES);
               req_d.op    = main_mem_write_req ? OP_WR : OP_RD;
               req_d.blk   = main_mem_addr[31:OFFSET_BITS];
               req_d.word  = main_mem_addr[OFFSET_BITS-1:2];
               req_d.wdata = main_mem_data_out;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               err_d   = ~in_range;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      main_mem_ready    = (state_q == ST_DONE);
      main_mem_busy     = (state_q != ST_IDLE);
      main_mem_addr_err = main_mem_ready && err_q;
      // Reset on the completing edge must abort the write as well as the FSM.
      arr_wr_en  = perform && !rst && (req_q.op == OP_WR) && in_range;
      arr_rd_en  = perform && (req_q.op == OP_RD) && in_range;
      arr_rd_clr = perform && (req_q.op == OP_RD) && !in_range;
   end

   main_mem_array #(
      .DEPTH_BLOCKS (DEPTH_BLOCKS),
      .INIT_PATTERN (INIT_PATTERN),
      .IDX_W        (IDX_W)
   ) u_array (
      .clk    (clk),
      .rst    (rst),
      .rd_en  (arr_rd_en),
      .rd_clr (arr_rd_clr),
      .wr_en  (arr_wr_en),
      .idx    (req_q.blk[IDX_W-1:0]),
      .word   (req_q.word),
      .wdata  (req_q.wdata),
      .rdata  (main_mem_data_in)
   );

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: directed scenarios plus randomized traffic
// checked cycle-by-cycle against an array-based reference model of the memory.
module tb_main_mem_responder;

   logic         clk;
   logic         rst;
   logic [31:0]  main_mem_addr;
   logic [31:0]  main_mem_data_out;
   logic         main_mem_read_req;
   logic         main_mem_write_req;
   logic [511:0] main_mem_data_in;
   logic         main_mem_ready;
   logic         main_mem_busy;
   logic         main_mem_addr_err;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [511:0] model_mem [1024];
   logic [511:0] model_last;

   main_mem_responder #(
      .LATENCY_CYCLES (3),
      .DEPTH_BLOCKS   (1024),
      .INIT_PATTERN   (1)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .main_mem_addr      (main_mem_addr),
      .main_mem_data_out  (main_mem_data_out),
      .main_mem_read_req  (main_mem_read_req),
      .main_mem_write_req (main_mem_write_req),
      .main_mem_data_in   (main_mem_data_in),
      .main_mem_ready     (main_mem_ready),
      .main_mem_busy      (main_mem_busy),
      .main_mem_addr_err  (main_mem_addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory semantics straight from the rules: block = addr/64, word = (addr/4)%16.
   task automatic model_apply(input bit is_wr, input logic [31:0] a, input logic [31:0] wd,
                              output bit exp_err, output logic [511:0] exp_data);
      int unsigned blk;
      int unsigned word;
      blk  = a / 64;
      word = (a / 4) % 16;
      exp_err = (blk >= 1024);
      if (is_wr) begin
         if (!exp_err) model_mem[blk][word*32 +: 32] = wd;
      end else begin
         model_last = exp_err ? '0 : model_mem[blk];
      end
      exp_data = model_last;
   endtask

   // Called just after the accept edge; walks the three WAIT cycles, DONE and return to IDLE.
   task automatic await_done(input string tag, input bit exp_err, input logic [511:0] exp_data,
                             input bit pulse);
      for (int i = 0; i < 3; i++) begin
         if (pulse && i == 0) begin
            main_mem_read_req  = 1'b1;
            main_mem_write_req = 1'b1;
            main_mem_addr      = $urandom_range(0, 16'hFFFF);
            main_mem_data_out  = $urandom;
         end
         step();
         if (pulse && i == 0) begin
            main_mem_read_req  = 1'b0;
            main_mem_write_req = 1'b0;
         end
         check({tag, " wait ready"}, 512'(main_mem_ready), 512'(1'b0));
         check({tag, " wait busy"}, 512'(main_mem_busy), 512'(1'b1));
      end
      step();
      check({tag, " done ready"}, 512'(main_mem_ready), 512'(1'b1));
      check({tag, " done busy"}, 512'(main_mem_busy), 512'(1'b1));
      check({tag, " done addr_err"}, 512'(main_mem_addr_err), 512'(exp_err));
      check({tag, " done data_in"}, main_mem_data_in, exp_data);
      step();
      check({tag, " idle ready"}, 512'(main_mem_ready), 512'(1'b0));
      check({tag, " idle busy"}, 512'(main_mem_busy), 512'(1'b0));
      check({tag, " idle addr_err"}, 512'(main_mem_addr_err), 512'(1'b0));
   endtask

   task automatic issue(input string tag, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, input bit pulse);
      bit           e;
      logic [511:0] d;
      main_mem_addr      = a;
      main_mem_data_out  = wd;
      main_mem_read_req  = rd;
      main_mem_write_req = wr;
      step();
      if (!hold) begin
         main_mem_read_req  = 1'b0;
         main_mem_write_req = 1'b0;
         main_mem_addr      = $urandom;
         main_mem_data_out  = $urandom;
      end
      check({tag, " accept busy"}, 512'(main_mem_busy), 512'(1'b1));
      check({tag, " accept ready"}, 512'(main_mem_ready), 512'(1'b0));
      model_apply(wr, a, wd, e, d);
      await_done(tag, e, d, pulse);
   endtask

   initial begin
      bit           e;
      logic [511:0] d;

      for (int i = 0; i < 1024; i++) model_mem[i] = 512'(i);
      model_last         = '0;
      rst                = 1'b1;
      main_mem_addr      = '0;
      main_mem_data_out  = '0;
      main_mem_read_req  = 1'b0;
      main_mem_write_req = 1'b0;
      step();
      step();
      check("reset ready", 512'(main_mem_ready), 512'(1'b0));
      check("reset busy", 512'(main_mem_busy), 512'(1'b0));
      check("reset addr_err", 512'(main_mem_addr_err), 512'(1'b0));
      check("reset data_in", main_mem_data_in, 512'd0);
      rst = 1'b0;
      step();

      // Test 1: block 64 read
      issue("t1 read 0x1000", 1'b1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 1'b0);
      check("t1 data const", main_mem_data_in, 512'd64);

      // Test 2: word write then block read
      issue("t2 write 0x2008", 1'b0, 1'b1, 32'h0000_2008, 32'hCAFE_BABE, 1'b0, 1'b0);
      check("t2 data after write", main_mem_data_in, 512'd64);
      issue("t2 read 0x2000", 1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 1'b0);
      check("t2 word2", 512'(main_mem_data_in[95:64]), 512'(32'hCAFE_BABE));
      check("t2 word0", 512'(main_mem_data_in[31:0]), 512'(32'd128));

      // Test 3: simultaneous read and write, write wins
      issue("t3 both 0x40", 1'b1, 1'b1, 32'h0000_0040, 32'h1234_5678, 1'b0, 1'b0);
      check("t3 data kept", main_mem_data_in[31:0] == 32'd128 ? 512'd1 : 512'd0, 512'd1);
      issue("t3 read 0x40", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 1'b0, 1'b0);

      // Test 4: out-of-range read and write; an aliased write would land in block 0
      issue("t4 oor read", 1'b1, 1'b0, 32'h0001_0000, 32'h0, 1'b0, 1'b0);
      issue("t4 oor write", 1'b0, 1'b1, 32'h0001_0000, 32'hDEAD_0001, 1'b0, 1'b0);
      issue("t4 read blk0", 1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0);

      // Test 5: held read across DONE, plus requests pulsed during WAIT
      issue("t5 held read", 1'b1, 1'b0, 32'h0000_0080, 32'h0, 1'b1, 1'b0);
      step();
      check("t5 reaccept busy", 512'(main_mem_busy), 512'(1'b1));
      check("t5 reaccept ready", 512'(main_mem_ready), 512'(1'b0));
      main_mem_read_req = 1'b0;
      model_apply(1'b0, 32'h0000_0080, 32'h0, e, d);
      await_done("t5 second read", e, d, 1'b1);
      issue("t5 pulsed wait", 1'b1, 1'b0, 32'h0000_00C0, 32'h0, 1'b0, 1'b1);

      // Test 6: reset two cycles after a write accept to block 5
      main_mem_addr      = 32'h0000_0140;
      main_mem_data_out  = 32'hBAD0_BAD0;
      main_mem_write_req = 1'b1;
      step();
      main_mem_write_req = 1'b0;
      check("t6 accept busy", 512'(main_mem_busy), 512'(1'b1));
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6 rst ready", 512'(main_mem_ready), 512'(1'b0));
      check("t6 rst busy", 512'(main_mem_busy), 512'(1'b0));
      check("t6 rst data_in", main_mem_data_in, 512'd0);
      model_last = '0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t6 no ready", 512'(main_mem_ready), 512'(1'b0));
         check("t6 idle busy", 512'(main_mem_busy), 512'(1'b0));
      end
      issue("t6 read blk5", 1'b1, 1'b0, 32'h0000_0140, 32'h0, 1'b0, 1'b0);
      check("t6 blk5 const", main_mem_data_in, 512'd5);

      // Randomized traffic over a small hot set, high blocks and out-of-range blocks
      for (int n = 0; n < 40; n++) begin
         int unsigned  kind;
         int unsigned  sel;
         logic [25:0]  blk;
         logic [31:0]  a;
         bit           rd;
         bit           wr;
         kind = $urandom_range(0, 2);
         sel  = $urandom_range(0, 9);
         if (sel == 0)      blk = 26'(1024 + $urandom_range(0, 50000));
         else if (sel == 1) blk = 26'($urandom_range(1000, 1023));
         else               blk = 26'($urandom_range(0, 15));
         a  = {blk, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
         rd = (kind != 1);
         wr = (kind != 0);
         issue($sformatf("rand%0d", n), rd, wr, a, $urandom, 1'b0, 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
